// File: rtl/stack_link_pkg.sv
// Shared encodings for the stack/link sequencer: op codes, FSM states, error codes.
package stack_link_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MEM    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  // PUSH and CALL grow the stack; POP and RET shrink it.
  function automatic logic is_push_side(op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_link_engine_if.sv
// Data-memory request/acknowledge bus between the stack engine and data memory.
interface stack_link_engine_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/stack_bounds_chk.sv
// Combinational stack bounds check on the SP seen at command accept.
module stack_bounds_chk
  import stack_link_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = 32'h0000_FFFC,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_F000
) (
  input  logic [31:0] sp,
  input  op_e         op,
  output logic        ovf,
  output logic        udf
);

  logic [31:0] sp_dec;

  assign sp_dec = sp - 32'(WORD_BYTES);

  // An SP below one word would wrap on decrement; that is an overflow, not a huge address.
  assign ovf = is_push_side(op) && ((sp < 32'(WORD_BYTES)) || (sp_dec < STACK_LIMIT));
  assign udf = !is_push_side(op) && (sp >= STACK_TOP);

endmodule

// File: rtl/stack_link_engine.sv
// PUSH/POP/CALL/RET sequencer: one memory access per command, then a single
// COMMIT cycle of SP/LR/PC write strobes into the special register file.
module stack_link_engine
  import stack_link_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = 32'h0000_FFFC,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_F000,
  parameter int          MAX_WAIT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_op,
  input  logic [31:0]                cmd_data,
  output logic                       cmd_ready,
  input  logic [31:0]                re_sp,
  input  logic [31:0]                re_lr,
  input  logic [31:0]                re_pc,
  output logic                       wr_sp,
  output logic [31:0]                wr_sp_data,
  output logic                       wr_lr,
  output logic [31:0]                wr_lr_data,
  output logic                       wr_pc,
  output logic [31:0]                wr_pc_data,
  stack_link_engine_if.master        mem,
  output logic                       pop_valid,
  output logic [31:0]                pop_data,
  output logic                       err,
  output logic [1:0]                 err_code
);

  logic [1:0]  state;
  op_e         op;
  op_e         op_q;
  logic        push_side;
  logic        ovf;
  logic        udf;
  logic [31:0] sp_dec;
  logic [31:0] sp_inc;
  logic [31:0] nsp_q;
  logic [31:0] nlr_q;
  logic [31:0] npc_q;
  logic [7:0]  wait_cnt;

  assign op        = op_e'(cmd_op);
  assign push_side = is_push_side(op);
  assign sp_dec    = re_sp - 32'(WORD_BYTES);
  assign sp_inc    = re_sp + 32'(WORD_BYTES);
  assign cmd_ready = (state == ST_IDLE);

  stack_bounds_chk #(
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds (
    .sp  (re_sp),
    .op  (op),
    .ovf (ovf),
    .udf (udf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= OP_PUSH;
      nsp_q          <= '0;
      nlr_q          <= '0;
      npc_q          <= '0;
      wait_cnt       <= '0;
      wr_sp          <= 1'b0;
      wr_lr          <= 1'b0;
      wr_pc          <= 1'b0;
      wr_sp_data     <= '0;
      wr_lr_data     <= '0;
      wr_pc_data     <= '0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      pop_valid      <= 1'b0;
      pop_data       <= '0;
      err            <= 1'b0;
      err_code       <= '0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default here; a later assignment in
      // the same cycle wins, so each strobe lasts exactly one cycle without extra state.
      wr_sp     <= 1'b0;
      wr_lr     <= 1'b0;
      wr_pc     <= 1'b0;
      pop_valid <= 1'b0;
      err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op;
            nsp_q <= push_side ? sp_dec : sp_inc;
            nlr_q <= re_pc + 32'(WORD_BYTES);
            npc_q <= (op == OP_CALL) ? cmd_data : re_lr;
            if (ovf || udf) begin
              err      <= 1'b1;
              err_code <= ovf ? ERR_OVF : ERR_UDF;
              state    <= ST_ERR;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= push_side;
              mem.mem_addr  <= push_side ? sp_dec : re_sp;
              mem.mem_wdata <= (op == OP_CALL) ? re_lr : cmd_data;
              wait_cnt      <= '0;
              state         <= ST_MEM;
            end
          end
        end

        ST_MEM: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            state       <= ST_COMMIT;
            wr_sp       <= 1'b1;
            wr_sp_data  <= nsp_q;
            case (op_q)
              OP_POP: begin
                pop_valid <= 1'b1;
                pop_data  <= mem.mem_rdata;
              end
              OP_CALL: begin
                wr_lr      <= 1'b1;
                wr_lr_data <= nlr_q;
                wr_pc      <= 1'b1;
                wr_pc_data <= npc_q;
              end
              OP_RET: begin
                wr_lr      <= 1'b1;
                wr_lr_data <= mem.mem_rdata;
                wr_pc      <= 1'b1;
                wr_pc_data <= npc_q;
              end
              default: ;
            endcase
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            mem.mem_req <= 1'b0;
            err         <= 1'b1;
            err_code    <= ERR_TMO;
            state       <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_COMMIT: state <= ST_IDLE;

        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_link_engine.sv
// Self-checking bench for stack_link_engine: vector table plus hand-written
// timeout and reset sequences, with a scoreboard for commit/error outputs.
module tb_stack_link_engine;
  import stack_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [31:0] re_sp, re_lr, re_pc;
  logic        wr_sp, wr_lr, wr_pc;
  logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        err;
  logic [1:0]  err_code;

  stack_link_engine_if mem_if ();

  stack_link_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .re_sp      (re_sp),
    .re_lr      (re_lr),
    .re_pc      (re_pc),
    .wr_sp      (wr_sp),
    .wr_sp_data (wr_sp_data),
    .wr_lr      (wr_lr),
    .wr_lr_data (wr_lr_data),
    .wr_pc      (wr_pc),
    .wr_pc_data (wr_pc_data),
    .mem        (mem_if),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Observed/expected output event; data fields are zeroed when their strobe is low.
  typedef struct packed {
    logic        wsp;
    logic [31:0] spd;
    logic        wlr;
    logic [31:0] lrd;
    logic        wpc;
    logic [31:0] pcd;
    logic        popv;
    logic [31:0] popd;
    logic        errv;
    logic [1:0]  code;
  } obs_t;

  typedef struct {
    string       name;
    op_e         op;
    logic [31:0] data, sp, lr, pc;
    int          delay;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr, wdata;
    obs_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  obs_t exp_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk_obs(logic wsp, logic [31:0] spd, logic wlr, logic [31:0] lrd,
                                  logic wpc, logic [31:0] pcd, logic popv, logic [31:0] popd,
                                  logic errv, logic [1:0] code);
    obs_t o;
    o.wsp  = wsp;  o.spd  = wsp  ? spd  : '0;
    o.wlr  = wlr;  o.lrd  = wlr  ? lrd  : '0;
    o.wpc  = wpc;  o.pcd  = wpc  ? pcd  : '0;
    o.popv = popv; o.popd = popv ? popd : '0;
    o.errv = errv; o.code = errv ? code : '0;
    return o;
  endfunction

  function automatic obs_t err_obs(logic [1:0] code);
    return mk_obs(0, 0, 0, 0, 0, 0, 0, 0, 1, code);
  endfunction

  function automatic vec_t mk_vec(string name, op_e op, logic [31:0] data, logic [31:0] sp,
                                  logic [31:0] lr, logic [31:0] pc, int delay, logic [31:0] rdata,
                                  logic we, logic [31:0] addr, logic [31:0] wdata, obs_t exp);
    vec_t v;
    v.name = name; v.op = op; v.data = data; v.sp = sp; v.lr = lr; v.pc = pc;
    v.delay = delay; v.rdata = rdata; v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  function automatic logic [65:0] mem_view();
    return {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr,
            mem_if.mem_we ? mem_if.mem_wdata : 32'h0};
  endfunction

  // Scoreboard: every strobe/pop/err event must match the oldest expectation.
  always @(negedge clk) begin
    obs_t o;
    obs_t e;
    if (wr_sp || wr_lr || wr_pc || pop_valid || err) begin
      o = mk_obs(wr_sp, wr_sp_data, wr_lr, wr_lr_data, wr_pc, wr_pc_data,
                 pop_valid, pop_data, err, err_code);
      if (exp_q.size() == 0) begin
        check("unexpected_output", o, '0);
      end else begin
        e = exp_q.pop_front();
        check("output_event", o, e);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", cmd_ready, 1'b1);
  endtask

  task automatic issue(input op_e op, input logic [31:0] data, input logic [31:0] sp,
                       input logic [31:0] lr, input logic [31:0] pc);
    wait_ready();
    re_sp = sp; re_lr = lr; re_pc = pc;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back(v.exp);
    issue(v.op, v.data, v.sp, v.lr, v.pc);
    if (v.exp.errv) begin
      check({v.name, "_no_req"}, mem_if.mem_req, 1'b0);
      @(negedge clk);
      check({v.name, "_code_held"}, err_code, v.exp.code);
    end else begin
      check({v.name, "_req"}, mem_view(), {1'b1, v.we, v.addr, v.we ? v.wdata : 32'h0});
      for (int i = 1; i < v.delay; i++) begin
        @(negedge clk);
        check({v.name, "_req_hold"}, mem_view(), {1'b1, v.we, v.addr, v.we ? v.wdata : 32'h0});
      end
      mem_if.mem_ack = 1'b1;
      mem_if.mem_rdata = v.rdata;
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      mem_if.mem_rdata = 32'h0BAD_0BAD;
      check({v.name, "_commit_timing"}, {mem_if.mem_req, wr_sp}, 2'b01);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk_vec("push_basic", OP_PUSH, 32'hDEAD_BEEF, 32'h0000_FFFC, 0, 0, 3, 0,
                      1, 32'h0000_FFF8, 32'hDEAD_BEEF, mk_obs(1, 32'h0000_FFF8, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[1]  = mk_vec("pop_basic", OP_POP, 0, 32'h0000_FFF8, 0, 0, 2, 32'h0000_1234,
                      0, 32'h0000_FFF8, 0, mk_obs(1, 32'h0000_FFFC, 0, 0, 0, 0, 1, 32'h0000_1234, 0, 0));
    vecs[2]  = mk_vec("call", OP_CALL, 32'h0000_0200, 32'h0000_FFFC, 32'h40, 32'h100, 1, 0,
                      1, 32'h0000_FFF8, 32'h40, mk_obs(1, 32'h0000_FFF8, 1, 32'h104, 1, 32'h200, 0, 0, 0, 0));
    vecs[3]  = mk_vec("ret", OP_RET, 0, 32'h0000_FFF8, 32'h104, 32'h200, 4, 32'h40,
                      0, 32'h0000_FFF8, 0, mk_obs(1, 32'h0000_FFFC, 1, 32'h40, 1, 32'h104, 0, 0, 0, 0));
    vecs[4]  = mk_vec("push_ovf", OP_PUSH, 32'h1, 32'h0000_F000, 0, 0, 0, 0, 0, 0, 0, err_obs(2'd1));
    vecs[5]  = mk_vec("pop_udf", OP_POP, 0, 32'h0000_FFFC, 0, 0, 0, 0, 0, 0, 0, err_obs(2'd2));
    vecs[6]  = mk_vec("push_at_limit", OP_PUSH, 32'h55, 32'h0000_F004, 0, 0, 1, 0,
                      1, 32'h0000_F000, 32'h55, mk_obs(1, 32'h0000_F000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[7]  = mk_vec("push_sp0_wrap", OP_PUSH, 32'h2, 32'h0, 0, 0, 0, 0, 0, 0, 0, err_obs(2'd1));
    vecs[8]  = mk_vec("ret_udf_high", OP_RET, 0, 32'hFFFF_0000, 0, 0, 0, 0, 0, 0, 0, err_obs(2'd2));
    vecs[9]  = mk_vec("call_pc_wrap", OP_CALL, 32'h300, 32'h0000_F800, 32'h7, 32'hFFFF_FFFC, 2, 0,
                      1, 32'h0000_F7FC, 32'h7, mk_obs(1, 32'h0000_F7FC, 1, 32'h0, 1, 32'h300, 0, 0, 0, 0));
    vecs[10] = mk_vec("pop_low", OP_POP, 0, 32'h0000_F000, 0, 0, 1, 32'hCAFE_F00D,
                      0, 32'h0000_F000, 0, mk_obs(1, 32'h0000_F004, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0));
    vecs[11] = mk_vec("push_sp4_ovf", OP_PUSH, 32'h3, 32'h4, 0, 0, 0, 0, 0, 0, 0, err_obs(2'd1));

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    re_sp = '0; re_lr = '0; re_pc = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state",
          {cmd_ready, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
           wr_sp, wr_lr, wr_pc, wr_sp_data, wr_lr_data, wr_pc_data,
           pop_valid, pop_data, err, err_code},
          {1'b1, 201'b0});

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Timeout: ack withheld for MAX_WAIT cycles, then a late ack must be ignored.
    exp_q.push_back(err_obs(2'd3));
    issue(OP_PUSH, 32'h1111_2222, 32'h0000_FFFC, 0, 0);
    check("tmo_req", mem_if.mem_req, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      check("tmo_req_hold", mem_if.mem_req, 1'b1);
    end
    @(negedge clk);
    check("tmo_req_dropped", {mem_if.mem_req, err}, 2'b01);
    @(negedge clk);
    check("tmo_idle", cmd_ready, 1'b1);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_late_ack_ignored", {cmd_ready, mem_if.mem_req, err_code}, {1'b1, 1'b0, 2'd3});

    // Reset while a request is outstanding: abandon it, no strobes afterwards.
    issue(OP_PUSH, 32'h3333_4444, 32'h0000_FFFC, 0, 0);
    check("rst_req", mem_if.mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    mem_if.mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_if.mem_ack = 1'b0;
    check("rst_abort", {cmd_ready, mem_if.mem_req, wr_sp, err_code}, {1'b1, 1'b0, 1'b0, 2'd0});
    repeat (3) @(negedge clk);
    check("rst_quiet", {cmd_ready, mem_if.mem_req}, 2'b10);

    run_vec(vecs[0]);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
